// File: rtl/lns_mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module : lns_mac_pkg
//  Brief  : Shared constants, operand type and LUT generator for the LNS MAC
//           and its lin-to-log front-end.
//  Contents:
//    IN_BITS        - log-domain magnitude width (operand is IN_BITS+1 signed)
//    LOG_ZERO       - encoding of log2(0): most negative operand value
//    LIN_*_DEFAULT  - default lin-side widths for the converter
//    lns_operand_t  - {log, nat_sign} operand as consumed by the MAC
//    log2_frac()    - elaboration-time log2 fraction generator
//  Rev    : 1.0  initial release
// ============================================================================
package lns_mac_pkg;

   localparam int IN_BITS = 15;
   localparam logic signed [IN_BITS:0] LOG_ZERO = {1'b1, {IN_BITS{1'b0}}};

   localparam int LIN_BITS_DEFAULT  = 16;
   localparam int FRAC_BITS_DEFAULT = 10;
   localparam int MANT_BITS_DEFAULT = 6;

   // Fixed-point precision and extra result bits used by log2_frac so the
   // final rounding step sees the exact value well past the rounding point.
   localparam int LOG2_PREC  = 48;
   localparam int LOG2_GUARD = 16;

   typedef struct packed {
      logic signed [IN_BITS:0] log;
      logic                    nat_sign;
   } lns_operand_t;

   // round(log2(1 + m/2^mant_bits) * 2^frac_bits), computed bit-serially by
   // repeated squaring of the normalised mantissa: each squaring that
   // crosses 2.0 contributes a 1 to the next fractional bit.
   function automatic logic [31:0] log2_frac(input int unsigned m,
                                             input int unsigned mant_bits,
                                             input int unsigned frac_bits);
      logic [127:0] x;
      logic [63:0]  r;
      x = (128'(1) << mant_bits) + 128'(m);
      x = x << (LOG2_PREC - mant_bits);
      r = '0;
      for (int i = 0; i < int'(frac_bits) + LOG2_GUARD; i++) begin
         x = (x * x) >> LOG2_PREC;
         r = r << 1;
         if (x >= (128'(2) << LOG2_PREC)) begin
            x = x >> 1;
            r = r | 64'd1;
         end
      end
      r = (r + (64'd1 << (LOG2_GUARD - 1))) >> LOG2_GUARD;
      return r[31:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/lns_log2_lut.sv
`default_nettype none
// ============================================================================
//  Module : lns_log2_lut
//  Brief  : Combinational log2 fraction table, MANT_BITS -> FRAC_BITS.
//           frac = round(log2(1 + mant/2^MANT_BITS) * 2^FRAC_BITS).
//  Ports  :
//    mant  in  MANT_BITS  mantissa bits below the leading one
//    frac  out FRAC_BITS  fractional part of log2
//  Rev    : 1.0  initial release
// ============================================================================
module lns_log2_lut
   import lns_mac_pkg::*;
#(
   parameter int MANT_BITS = 6,
   parameter int FRAC_BITS = 10
) (
   input  logic [MANT_BITS-1:0] mant,
   output logic [FRAC_BITS-1:0] frac
);

   localparam int DEPTH = 1 << MANT_BITS;

   logic [FRAC_BITS-1:0] lut_w [DEPTH];

   // Table contents are constants folded at elaboration time.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign lut_w[gi] = FRAC_BITS'(log2_frac(gi, MANT_BITS, FRAC_BITS));
   end

   assign frac = lut_w[mant];

endmodule
`default_nettype wire

// File: rtl/lns_lin2log_pair.sv
`default_nettype none
// ============================================================================
//  Module : lns_lin2log_pair
//  Brief  : Two-stage converter from a pair of signed linear integers to the
//           LNS MAC operand format {signed log2|v| fixed point, nat_sign}.
//           Stage 1 registers sign, |v|, zero flag and leading-one index;
//           stage 2 looks up the fraction and registers the log value.
//  Ports  :
//    clk, rstn (async active-low), flush (sync, drops in-flight pairs)
//    in_valid/in_ready, in_x, in_y        - linear input pair
//    out_valid/out_ready                  - to MAC data_in_valid/enable
//    out_x_log, out_y_log                 - signed log2 magnitudes
//    out_x_nat_sign, out_y_nat_sign       - 1 = >= 0, 0 = negative
//  Rev    : 1.0  initial release
// ============================================================================
module lns_lin2log_pair
   import lns_mac_pkg::*;
#(
   parameter int LIN_BITS  = LIN_BITS_DEFAULT,
   parameter int FRAC_BITS = FRAC_BITS_DEFAULT,
   parameter int MANT_BITS = MANT_BITS_DEFAULT
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LIN_BITS-1:0]       in_x,
   input  logic [LIN_BITS-1:0]       in_y,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [IN_BITS:0]   out_x_log,
   output logic signed [IN_BITS:0]   out_y_log,
   output logic                      out_x_nat_sign,
   output logic                      out_y_nat_sign
);

   localparam int KW = $clog2(LIN_BITS);

   // Largest log value must fit below the sign bit of the operand.
   if ((((LIN_BITS - 1) << FRAC_BITS) + (1 << FRAC_BITS) - 1) >= (1 << IN_BITS)) begin : g_bad_log_width
      $error("lns_lin2log_pair: log range exceeds operand width");
   end
   if (MANT_BITS > LIN_BITS - 1) begin : g_bad_mant_width
      $error("lns_lin2log_pair: MANT_BITS must not exceed LIN_BITS-1");
   end

   // ------------------------------------------------------------------
   // Handshake / stage valids
   // ------------------------------------------------------------------
   logic s1_valid_q, s1_valid_d;
   logic s2_valid_q, s2_valid_d;
   logic e1, e2, ld1, ld2;

   assign e2       = !s2_valid_q | out_ready;
   assign e1       = !s1_valid_q | e2;
   assign in_ready = e1;
   assign ld1      = in_valid & e1 & !flush;
   assign ld2      = s1_valid_q & e2 & !flush;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s2_valid_d = s2_valid_q;
      if (flush) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end else begin
         if (e1) s1_valid_d = in_valid;
         if (e2) s2_valid_d = s1_valid_q;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
      end
   end

   // ------------------------------------------------------------------
   // Per-operand datapath (x = 0, y = 1)
   // ------------------------------------------------------------------
   logic [LIN_BITS-1:0] lin_in [2];
   lns_operand_t        op_res [2];

   assign lin_in[0] = in_x;
   assign lin_in[1] = in_y;

   for (genvar gi = 0; gi < 2; gi++) begin : g_op
      logic [LIN_BITS-1:0]  mag_new;
      logic [KW-1:0]        k_new;
      logic                 sign_q, sign_d;
      logic                 zero_q, zero_d;
      logic [LIN_BITS-1:0]  mag_q, mag_d;
      logic [KW-1:0]        k_q, k_d;
      logic [LIN_BITS-1:0]  norm;
      logic [MANT_BITS-1:0] mant;
      logic [FRAC_BITS-1:0] frac;
      lns_operand_t         res_q, res_d;

      // Two's-complement magnitude as unsigned: -2^(LIN_BITS-1) maps to
      // 2^(LIN_BITS-1), which still fits the unsigned width.
      assign mag_new = lin_in[gi][LIN_BITS-1]
                     ? (~lin_in[gi] + {{(LIN_BITS-1){1'b0}}, 1'b1})
                     : lin_in[gi];

      always_comb begin
         k_new = '0;
         for (int b = 0; b < LIN_BITS; b++) begin
            if (mag_new[b]) k_new = KW'(b);
         end
      end

      always_comb begin
         sign_d = sign_q;
         zero_d = zero_q;
         mag_d  = mag_q;
         k_d    = k_q;
         if (ld1) begin
            sign_d = !lin_in[gi][LIN_BITS-1];
            zero_d = (mag_new == '0);
            mag_d  = mag_new;
            k_d    = k_new;
         end
      end

      // Left-justify the leading one at the MSB; the MANT_BITS below it
      // form the mantissa, zero-padded when k < MANT_BITS.
      assign norm = mag_q << (KW'(LIN_BITS - 1) - k_q);
      assign mant = MANT_BITS'(norm >> (LIN_BITS - 1 - MANT_BITS));

      lns_log2_lut #(
         .MANT_BITS (MANT_BITS),
         .FRAC_BITS (FRAC_BITS)
      ) u_lut (
         .mant (mant),
         .frac (frac)
      );

      always_comb begin
         res_d = res_q;
         if (ld2) begin
            res_d.nat_sign = sign_q;
            // frac < 2^FRAC_BITS, so concatenation equals (k << FRAC) + frac.
            res_d.log = zero_q ? LOG_ZERO : (IN_BITS + 1)'({k_q, frac});
         end
      end

      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            sign_q <= 1'b0;
            zero_q <= 1'b0;
            mag_q  <= '0;
            k_q    <= '0;
            res_q  <= '0;
         end else begin
            sign_q <= sign_d;
            zero_q <= zero_d;
            mag_q  <= mag_d;
            k_q    <= k_d;
            res_q  <= res_d;
         end
      end

      assign op_res[gi] = res_q;
   end

   assign out_valid      = s2_valid_q;
   assign out_x_log      = op_res[0].log;
   assign out_y_log      = op_res[1].log;
   assign out_x_nat_sign = op_res[0].nat_sign;
   assign out_y_nat_sign = op_res[1].nat_sign;

endmodule
`default_nettype wire

// File: tb/tb_lns_lin2log_pair.sv
`default_nettype none
// ============================================================================
//  Module : tb_lns_lin2log_pair
//  Brief  : Directed self-checking bench for lns_lin2log_pair
//           (LIN=16, FRAC=10, MANT=6, IN_BITS=15).
//  Rev    : 1.0  initial release
// ============================================================================
module tb_lns_lin2log_pair;

   logic               clk = 1'b0;
   logic               rstn = 1'b0;
   logic               flush = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [15:0]        in_x = '0;
   logic [15:0]        in_y = '0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic signed [15:0] out_x_log;
   logic signed [15:0] out_y_log;
   logic               out_x_nat_sign;
   logic               out_y_nat_sign;

   int errors = 0;
   int checks = 0;

   lns_lin2log_pair #(
      .LIN_BITS  (16),
      .FRAC_BITS (10),
      .MANT_BITS (6)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
      .flush          (flush),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_x           (in_x),
      .in_y           (in_y),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_x_log      (out_x_log),
      .out_y_log      (out_y_log),
      .out_x_nat_sign (out_x_nat_sign),
      .out_y_nat_sign (out_y_nat_sign)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One isolated pair: two-cycle latency, single-cycle output, then idle.
   task automatic single(input string tag, input logic [15:0] x, input logic [15:0] y,
                         input int xl, input int xs, input int yl, input int ys);
      in_x = x; in_y = y; in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      chk({tag, ".lat1_valid"}, out_valid, 0);
      cyc();
      chk({tag, ".valid"}, out_valid, 1);
      chk({tag, ".xlog"}, out_x_log, xl);
      chk({tag, ".xsign"}, out_x_nat_sign, xs);
      chk({tag, ".ylog"}, out_y_log, yl);
      chk({tag, ".ysign"}, out_y_nat_sign, ys);
      cyc();
      chk({tag, ".drained"}, out_valid, 0);
   endtask

   int          sv_log [5];
   logic [15:0] sv_lin [5];
   int          sent;
   int          recv;

   initial begin
      // Reset state
      cyc();
      chk("rst.out_valid", out_valid, 0);
      chk("rst.in_ready", in_ready, 1);
      chk("rst.xlog", out_x_log, 0);
      chk("rst.ylog", out_y_log, 0);
      chk("rst.xsign", out_x_nat_sign, 0);
      chk("rst.ysign", out_y_nat_sign, 0);
      cyc();
      rstn = 1'b1;
      cyc();

      // Directed conversions (hand-computed log2 fixed-point values)
      single("v1", 16'd1,     16'd2,     0,      1, 1024,  1);
      single("v2", 16'd3,     -16'sd8,   1623,   1, 3072,  0);
      single("v3", 16'd0,     16'h8000,  -32768, 1, 15360, 0);
      single("v4", 16'd5,     16'd7,     2378,   1, 2875,  1);
      single("v5", -16'sd9,   16'd1000,  3246,   0, 10205, 1);
      single("v6", 16'd32767, -16'sd1,   15348,  1, 0,     0);

      // Stream of 5 pairs with out_ready low for cycles 3..6
      sv_lin = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
      sv_log = '{0, 1024, 1623, 2048, 2378};
      sent = 0;
      recv = 0;
      for (int t = 0; t < 16; t++) begin
         out_ready = !(t >= 3 && t <= 6);
         in_valid  = (sent < 5);
         if (sent < 5) begin
            in_x = sv_lin[sent];
            in_y = -sv_lin[sent];
         end
         #1;
         if (t <= 7) chk($sformatf("stream.in_ready.t%0d", t), in_ready,
                         (t >= 3 && t <= 6) ? 0 : 1);
         if (out_valid && out_ready) begin
            if (recv < 5) begin
               chk($sformatf("stream.x%0d", recv), out_x_log, sv_log[recv]);
               chk($sformatf("stream.y%0d", recv), out_y_log, sv_log[recv]);
               chk($sformatf("stream.ys%0d", recv), out_y_nat_sign, 0);
            end else begin
               chk("stream.extra_output", recv, 4);
            end
            recv++;
         end
         if (in_valid && in_ready) sent++;
         cyc();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("stream.sent", sent, 5);
      chk("stream.recv", recv, 5);

      // Flush with both stages full and an input offered
      out_ready = 1'b0;
      in_valid = 1'b1; in_x = 16'd4; in_y = 16'd4;
      cyc();
      in_x = 16'd6; in_y = 16'd6;
      cyc();
      in_x = 16'd7; in_y = 16'd7;
      #1;
      chk("flush.pre_valid", out_valid, 1);
      chk("flush.pre_in_ready", in_ready, 0);
      chk("flush.pre_xlog", out_x_log, 2048);
      cyc();
      chk("flush.hold_xlog", out_x_log, 2048);
      chk("flush.hold_valid", out_valid, 1);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("flush.valid", out_valid, 0);
      chk("flush.in_ready", in_ready, 1);
      for (int t = 0; t < 3; t++) begin
         cyc();
         chk($sformatf("flush.quiet%0d", t), out_valid, 0);
      end

      // Reset mid-stream
      in_valid = 1'b1; in_x = 16'd3; in_y = 16'd3;
      cyc();
      in_x = 16'd5; in_y = 16'd5;
      cyc();
      in_valid = 1'b0;
      chk("rst2.pre_valid", out_valid, 1);
      rstn = 1'b0;
      #1;
      chk("rst2.valid", out_valid, 0);
      chk("rst2.in_ready", in_ready, 1);
      chk("rst2.xlog", out_x_log, 0);
      cyc();
      rstn = 1'b1;
      cyc();
      chk("rst2.idle", out_valid, 0);
      single("v7", 16'd12, -16'sd3, 3671, 1, 1623, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
